lab_exam: RTL and testbench

- Single-clock go-triggered up-counter with done flag.
- Asserting go from idle starts a count from 0 up to a limit. The block then raises done and holds it until go is released.
- Used as a small datapath-plus-controller unit. The 7-bit count value and done flag are visible to the surrounding logic.

---
 rtl/lab_exam.sv | 91 +++++++++
 tb/tb_lab_exam.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab_exam.sv
// ---------------------------------------------------------------------------
// lab_exam: go-triggered saturating up-counter with a done flag.
//
// A start request (go=1) seen in IDLE clears the counter and enters RUN.
// In RUN the counter advances by STEP on every rising edge and clamps at
// LIMIT; reaching LIMIT moves to DONE. DONE holds done=1 until go is
// released, then returns to IDLE. The count value is kept in IDLE until the
// next start clears it.
//
// Parameters:
//   LIMIT        terminal count, 1..127
//   STEP         increment per RUN cycle, 1..127
// Ports:
//   Clk          system clock, rising edge
//   Rst          asynchronous active-low reset
//   go           start request / release, level sensitive
//   count        registered 7-bit counter value
//   done         high only in DONE (decoded from the state register)
//   dbg_state_o  current state for checkers: 0=IDLE, 1=RUN, 2=DONE
// ---------------------------------------------------------------------------
module lab_exam #(
  parameter int LIMIT = 100,
  parameter int STEP  = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       go,
  output logic [6:0] count,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LIMIT_W = 8'(LIMIT);
  localparam logic [7:0] STEP_W  = 8'(STEP);
  localparam logic [6:0] LIMIT_C = 7'(LIMIT);

  state_e     state_q;
  logic [6:0] count_q;
  logic [7:0] sum_d;

  // One extra bit so count+STEP can never wrap before the LIMIT compare.
  always_comb begin
    sum_d = {1'b0, count_q} + STEP_W;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // go is deliberately ignored here: a started count always completes.
          if (sum_d >= LIMIT_W) begin
            count_q <= LIMIT_C;
            state_q <= DONE;
          end else begin
            count_q <= sum_d[6:0];
          end
        end
        DONE: begin
          // Holding go keeps us here, so a new run needs a go=0 edge first.
          if (!go) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign count       = count_q;
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lab_exam.sv
// ---------------------------------------------------------------------------
// tb_lab_exam: three lab_exam instances (100/1, 10/1, 10/3) checked every
// cycle against a behavioural model, plus directed scenario checks.
//
// valid/ready note: this block has no handshake; go is a plain level that
// is sampled on every rising Clk edge.
// ---------------------------------------------------------------------------
module tb_lab_exam;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic       go_w      [N];
  logic [6:0] count_w   [N];
  logic       done_w    [N];
  logic [1:0] state_w   [N];

  lab_exam #(.LIMIT(100), .STEP(1)) u_dflt (
    .Clk(Clk), .Rst(Rst), .go(go_w[0]),
    .count(count_w[0]), .done(done_w[0]), .dbg_state_o(state_w[0])
  );
  lab_exam #(.LIMIT(10), .STEP(1)) u_l10 (
    .Clk(Clk), .Rst(Rst), .go(go_w[1]),
    .count(count_w[1]), .done(done_w[1]), .dbg_state_o(state_w[1])
  );
  lab_exam #(.LIMIT(10), .STEP(3)) u_clamp (
    .Clk(Clk), .Rst(Rst), .go(go_w[2]),
    .count(count_w[2]), .done(done_w[2]), .dbg_state_o(state_w[2])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is described by k = edges since the start edge; the count is
  // min(k*STEP, LIMIT) and the run ends once k*STEP reaches LIMIT.
  int lim_m [N] = '{100, 10, 10};
  int stp_m [N] = '{1, 1, 3};
  bit busy_m [N];
  bit fin_m  [N];
  int k_m    [N];
  int cnt_m  [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 0; fin_m[i] = 0; k_m[i] = 0; cnt_m[i] = 0;
    end
  end

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < N; i++) begin
        busy_m[i] = 0; fin_m[i] = 0; k_m[i] = 0; cnt_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (fin_m[i]) begin
          if (!go_w[i]) fin_m[i] = 0;
        end else if (busy_m[i]) begin
          k_m[i]++;
          if (k_m[i] * stp_m[i] >= lim_m[i]) begin
            cnt_m[i]  = lim_m[i];
            busy_m[i] = 0;
            fin_m[i]  = 1;
          end else begin
            cnt_m[i] = k_m[i] * stp_m[i];
          end
        end else if (go_w[i]) begin
          busy_m[i] = 1;
          k_m[i]    = 0;
          cnt_m[i]  = 0;
        end
      end
    end
  end

  // Per-cycle scoreboard, sampled on the falling edge.
  bit check_en = 0;
  always @(negedge Clk) begin
    if (check_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cnt%0d", i), count_w[i], cnt_m[i]);
        check($sformatf("done%0d", i), done_w[i], fin_m[i]);
        check($sformatf("st%0d", i), state_w[i], fin_m[i] ? 2 : (busy_m[i] ? 1 : 0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic all_go(input logic v);
    for (int i = 0; i < N; i++) go_w[i] = v;
  endtask

  // Counts done-high cycles of one instance over a window.
  task automatic count_done(input int idx, input int cycles, output int hits);
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done_w[idx]) hits++;
    end
  endtask

  logic [6:0] exp_q[$];
  int hits;
  bit found;

  initial begin
    all_go(1'b1);
    Rst = 1'b0;
    #1 check_en = 1;

    // Reset held with go=1 for two edges.
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      check("rst_cnt", count_w[i], 0);
      check("rst_done", done_w[i], 0);
      check("rst_st", state_w[i], 0);
    end
    Rst = 1'b1;
    tick();
    check("start_cnt", count_w[0], 0);
    check("start_st", state_w[0], 1);
    tick();
    check("start_cnt1", count_w[0], 1);
    all_go(1'b0);
    repeat (110) tick();

    // Full default count from a one-edge go pulse.
    go_w[0] = 1'b1;
    tick();
    go_w[0] = 1'b0;
    count_done(0, 104, hits);
    check("full_done_cycles", hits, 1);
    check("full_end_cnt", count_w[0], 100);
    check("full_end_st", state_w[0], 0);

    // Held go on LIMIT=10: done rises 10 edges after the start edge.
    go_w[1] = 1'b1;
    tick();
    repeat (9) tick();
    check("held_pre_done", done_w[1], 0);
    tick();
    check("held_done", done_w[1], 1);
    check("held_cnt", count_w[1], 10);
    repeat (3) tick();
    check("held_stay", done_w[1], 1);
    go_w[1] = 1'b0;
    tick();
    check("held_release", done_w[1], 0);
    check("held_keep", count_w[1], 10);

    // go released mid-run: counting completes regardless.
    go_w[0] = 1'b1;
    repeat (8) tick();
    go_w[0] = 1'b0;
    count_done(0, 100, hits);
    check("mid_done_cycles", hits, 1);
    check("mid_end_cnt", count_w[0], 100);

    // Clamped sequence for LIMIT=10, STEP=3.
    exp_q = '{7'd0, 7'd3, 7'd6, 7'd9, 7'd10};
    go_w[2] = 1'b1;
    tick();
    go_w[2] = 1'b0;
    while (exp_q.size() > 0) begin
      check("clamp_seq", count_w[2], exp_q.pop_front());
      if (exp_q.size() > 0) tick();
    end
    check("clamp_done", done_w[2], 1);
    repeat (3) tick();

    // Asynchronous reset mid-run at count 37.
    go_w[0] = 1'b1;
    tick();
    go_w[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (count_w[0] == 7'd37) found = 1;
      else tick();
    end
    check("wait37", found, 1);
    #1 Rst = 1'b0;
    #1;
    check("async_cnt", count_w[0], 0);
    check("async_done", done_w[0], 0);
    #1 Rst = 1'b1;
    count_done(0, 110, hits);
    check("async_no_done", hits, 0);
    check("async_idle_cnt", count_w[0], 0);

    // Randomized go levels with rare mid-cycle resets.
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) go_w[i] = ~go_w[i];
      end
      if ($urandom_range(0, 299) == 0) begin
        Rst = 1'b0;
        #2 Rst = 1'b1;
      end
    end

    tick();
    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
